// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_pkg                                                          |
// | Purpose  : Shared definitions for the 16-point FFT datapath: default word   |
// |            width and Q format, complex sample type, frame-phase constants.  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fft_pkg;

  localparam int N_DEFAULT = 16;  // sample word width
  localparam int Q_DEFAULT = 8;   // fractional bits

  // One complex sample at the default word width.
  typedef struct packed {
    logic signed [N_DEFAULT-1:0] re;
    logic signed [N_DEFAULT-1:0] im;
  } cplx_t;

  // Frame phase is the low three bits of the free-running counter.
  typedef logic [2:0] phase_t;

  localparam phase_t PH_CAPTURE = 3'd0;
  localparam phase_t PH_MUL     = 3'd1;
  localparam phase_t PH_ADD     = 3'd2;
  localparam phase_t PH_DONE    = 3'd3;

endpackage
`default_nettype wire

// File: rtl/butterfly2_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : butterfly2_core_if                                               |
// | Purpose  : Operand/result bundle of the radix-2 butterfly.                  |
// | Signals  : i_in0_*, i_in1_*, i_twiddle_* - operands (re/im, N bits)         |
// |            o_out0_*, o_out1_*            - results  (re/im, N bits)         |
// |            o_butterfly_done              - one-cycle result-update pulse    |
// | Modports : master - operand source / result sink                           |
// |            slave  - the butterfly core                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface butterfly2_core_if
  import fft_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic signed [N-1:0] i_in0_re;
  logic signed [N-1:0] i_in0_im;
  logic signed [N-1:0] i_in1_re;
  logic signed [N-1:0] i_in1_im;
  logic signed [N-1:0] i_twiddle_re;
  logic signed [N-1:0] i_twiddle_im;
  logic signed [N-1:0] o_out0_re;
  logic signed [N-1:0] o_out0_im;
  logic signed [N-1:0] o_out1_re;
  logic signed [N-1:0] o_out1_im;
  logic                o_butterfly_done;

  modport master (
    output i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im,
    input  o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_butterfly_done
  );

  modport slave (
    input  i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im,
    output o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_butterfly_done
  );

endinterface
`default_nettype wire

// File: rtl/cmul_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cmul_q                                                           |
// | Purpose  : Registered complex multiplier p = a * b in Q format. The four    |
// |            partial products are registered when i_en is high; the sum,     |
// |            floor shift by Q and truncation to N bits are combinational.    |
// | Ports    : i_clk, i_rst (async, active-low), i_en (product load)           |
// |            i_a_re/im, i_b_re/im - N-bit signed operands                    |
// |            o_p_re/im            - N-bit signed Q-format product            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cmul_q
  import fft_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int Q = Q_DEFAULT
) (
  input  wire                 i_clk,
  input  wire                 i_rst,
  input  wire                 i_en,
  input  wire signed [N-1:0]  i_a_re,
  input  wire signed [N-1:0]  i_a_im,
  input  wire signed [N-1:0]  i_b_re,
  input  wire signed [N-1:0]  i_b_im,
  output logic signed [N-1:0] o_p_re,
  output logic signed [N-1:0] o_p_im
);

  logic signed [2*N-1:0] r_rr;
  logic signed [2*N-1:0] r_ii;
  logic signed [2*N-1:0] r_ri;
  logic signed [2*N-1:0] r_ir;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr <= '0;
      r_ii <= '0;
      r_ri <= '0;
      r_ir <= '0;
    end else if (i_en) begin
      r_rr <= i_a_re * i_b_re;
      r_ii <= i_a_im * i_b_im;
      r_ri <= i_a_re * i_b_im;
      r_ir <= i_a_im * i_b_re;
    end
  end

  // One guard bit so the sum/difference of two full-range products is exact.
  logic signed [2*N:0] w_pr;
  logic signed [2*N:0] w_pi;
  logic signed [2*N:0] w_pr_sh;
  logic signed [2*N:0] w_pi_sh;

  assign w_pr    = {r_rr[2*N-1], r_rr} - {r_ii[2*N-1], r_ii};
  assign w_pi    = {r_ri[2*N-1], r_ri} + {r_ir[2*N-1], r_ir};
  // Arithmetic shift = floor; the upper bits are dropped, so overflow wraps.
  assign w_pr_sh = w_pr >>> Q;
  assign w_pi_sh = w_pi >>> Q;
  assign o_p_re  = w_pr_sh[N-1:0];
  assign o_p_im  = w_pi_sh[N-1:0];

  logic w_unused;
  assign w_unused = ^{w_pr_sh[2*N:N], w_pi_sh[2*N:N]};

endmodule
`default_nettype wire

// File: rtl/butterfly2_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : butterfly2_core                                                  |
// | Purpose  : Radix-2 butterfly out0 = in0 + W*in1, out1 = in0 - W*in1 over a |
// |            fixed 8-cycle frame, plus /8 and /16 pacing clocks.             |
// | Ports    : i_clk         - system clock, rising edge                       |
// |            i_rst         - async reset, active-low                         |
// |            bus (slave)   - operands, results and done pulse                |
// |            clk_divided8  - i_clk/8, 50% duty                               |
// |            clk_divided16 - i_clk/16, 50% duty                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module butterfly2_core
  import fft_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int Q = Q_DEFAULT
) (
  input  wire              i_clk,
  input  wire              i_rst,
  butterfly2_core_if.slave bus,
  output logic             clk_divided8,
  output logic             clk_divided16
);

  logic [3:0]          r_cnt;
  phase_t              w_phase;
  logic signed [N-1:0] r_in0_re;
  logic signed [N-1:0] r_in0_im;
  logic signed [N-1:0] r_in1_re;
  logic signed [N-1:0] r_in1_im;
  logic signed [N-1:0] r_tw_re;
  logic signed [N-1:0] r_tw_im;
  logic signed [N-1:0] w_p_re;
  logic signed [N-1:0] w_p_im;
  logic signed [N-1:0] r_out0_re;
  logic signed [N-1:0] r_out0_im;
  logic signed [N-1:0] r_out1_re;
  logic signed [N-1:0] r_out1_im;
  logic                r_done;

  // The frame counter doubles as the divider source, so the pacing clocks
  // stay phase-locked to the butterfly frame.
  assign w_phase       = r_cnt[2:0];
  assign clk_divided8  = r_cnt[2];
  assign clk_divided16 = r_cnt[3];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Operands are only sampled at the capture phase; changes elsewhere are ignored.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_in0_re <= '0;
      r_in0_im <= '0;
      r_in1_re <= '0;
      r_in1_im <= '0;
      r_tw_re  <= '0;
      r_tw_im  <= '0;
    end else if (w_phase == PH_CAPTURE) begin
      r_in0_re <= bus.i_in0_re;
      r_in0_im <= bus.i_in0_im;
      r_in1_re <= bus.i_in1_re;
      r_in1_im <= bus.i_in1_im;
      r_tw_re  <= bus.i_twiddle_re;
      r_tw_im  <= bus.i_twiddle_im;
    end
  end

  cmul_q #(
    .N (N),
    .Q (Q)
  ) u_cmul (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_phase == PH_MUL),
    .i_a_re (r_tw_re),
    .i_a_im (r_tw_im),
    .i_b_re (r_in1_re),
    .i_b_im (r_in1_im),
    .o_p_re (w_p_re),
    .o_p_im (w_p_im)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out0_re <= '0;
      r_out0_im <= '0;
      r_out1_re <= '0;
      r_out1_im <= '0;
      r_done    <= 1'b0;
    end else if (w_phase == PH_ADD) begin
      r_out0_re <= r_in0_re + w_p_re;
      r_out0_im <= r_in0_im + w_p_im;
      r_out1_re <= r_in0_re - w_p_re;
      r_out1_im <= r_in0_im - w_p_im;
      r_done    <= 1'b1;
    end else if (w_phase == PH_DONE) begin
      r_done    <= 1'b0;
    end
  end

  assign bus.o_out0_re        = r_out0_re;
  assign bus.o_out0_im        = r_out0_im;
  assign bus.o_out1_re        = r_out1_re;
  assign bus.o_out1_im        = r_out1_im;
  assign bus.o_butterfly_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_butterfly2_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_butterfly2_core                                               |
// | Purpose  : Self-checking bench for butterfly2_core: directed vectors,       |
// |            random operands, divider/done timing and mid-frame reset,       |
// |            all compared against an arithmetic reference model.            |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_butterfly2_core;
  import fft_pkg::*;

  localparam int N = N_DEFAULT;
  localparam int Q = Q_DEFAULT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic div8;
  logic div16;

  butterfly2_core_if #(.N(N)) bif ();

  butterfly2_core #(
    .N (N),
    .Q (Q)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .bus           (bif),
    .clk_divided8  (div8),
    .clk_divided16 (div16)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_bad   = 0;
  cplx_t in0, in1, tw;        // operands currently presented
  cplx_t cap0, cap1, capw;    // operands the model saw at the last capture
  cplx_t e_out0, e_out1;      // expected held results
  int    k;                   // rising edges since reset release

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference butterfly in plain integer arithmetic.
  function automatic void bfly(input cplx_t a, input cplx_t b, input cplx_t w,
                               output cplx_t o0, output cplx_t o1);
    longint      pr, pi;
    logic [15:0] p_re, p_im;
    pr = longint'($signed(w.re)) * longint'($signed(b.re))
       - longint'($signed(w.im)) * longint'($signed(b.im));
    pi = longint'($signed(w.re)) * longint'($signed(b.im))
       + longint'($signed(w.im)) * longint'($signed(b.re));
    pr = pr >>> Q;
    pi = pi >>> Q;
    p_re  = pr[15:0];
    p_im  = pi[15:0];
    o0.re = a.re + p_re;
    o0.im = a.im + p_im;
    o1.re = a.re - p_re;
    o1.im = a.im - p_im;
  endfunction

  task automatic drive();
    bif.i_in0_re     = in0.re;
    bif.i_in0_im     = in0.im;
    bif.i_in1_re     = in1.re;
    bif.i_in1_im     = in1.im;
    bif.i_twiddle_re = tw.re;
    bif.i_twiddle_im = tw.im;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic rand_inputs();
    in0.re = rnd_word(); in0.im = rnd_word();
    in1.re = rnd_word(); in1.im = rnd_word();
    tw.re  = rnd_word(); tw.im  = rnd_word();
    drive();
  endtask

  // Model view of one rising edge: capture at phase 0, results appear after phase 2.
  task automatic model_edge();
    if (k % 8 == 0) begin
      cap0 = in0; cap1 = in1; capw = tw;
    end
    if (k % 8 == 2) bfly(cap0, cap1, capw, e_out0, e_out1);
    k++;
  endtask

  task automatic check_all();
    chk_eq("out0_re", bif.o_out0_re, e_out0.re);
    chk_eq("out0_im", bif.o_out0_im, e_out0.im);
    chk_eq("out1_re", bif.o_out1_re, e_out1.re);
    chk_eq("out1_im", bif.o_out1_im, e_out1.im);
    chk_eq("done",  {15'b0, bif.o_butterfly_done}, (k % 8 == 3) ? 16'd1 : 16'd0);
    chk_eq("div8",  {15'b0, div8},  16'((k >> 2) & 1));
    chk_eq("div16", {15'b0, div16}, 16'((k >> 3) & 1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    k      = 0;
    e_out0 = '0;
    e_out1 = '0;
    #1;
    check_all();
  endtask

  // Present a vector for the next capture edge, scramble the inputs afterwards,
  // then check the result at the phase-3 cycle against the literal values.
  task automatic directed(input string tag, input cplx_t a, input cplx_t b, input cplx_t w,
                          input logic [15:0] r0re, input logic [15:0] r0im,
                          input logic [15:0] r1re, input logic [15:0] r1im);
    while (k % 8 != 0) step();
    in0 = a; in1 = b; tw = w;
    drive();
    step();
    rand_inputs();
    step();
    step();
    chk_eq({tag, "_done"},    {15'b0, bif.o_butterfly_done}, 16'd1);
    chk_eq({tag, "_out0_re"}, bif.o_out0_re, r0re);
    chk_eq({tag, "_out0_im"}, bif.o_out0_im, r0im);
    chk_eq({tag, "_out1_re"}, bif.o_out1_re, r1re);
    chk_eq({tag, "_out1_im"}, bif.o_out1_im, r1im);
  endtask

  initial begin
    in0 = '0; in1 = '0; tw = '0;
    cap0 = '0; cap1 = '0; capw = '0;
    k = 0;
    drive();
    #2;
    apply_reset();
    repeat (2) step();
    rst_n = 1'b1;

    directed("nominal",   '{16'h0300, 16'h0100}, '{16'h0200, 16'hFC00}, '{16'hFF00, 16'h0500},
             16'h1500, 16'h0F00, 16'hF100, 16'hF300);
    directed("identity",  '{16'h016A, 16'h00C9}, '{16'hFE96, 16'h00C9}, '{16'h0100, 16'h0000},
             16'h0000, 16'h0192, 16'h02D4, 16'h0000);
    directed("trunc",     '{16'h0000, 16'h0000}, '{16'hFFFF, 16'h0000}, '{16'h0080, 16'h0000},
             16'hFFFF, 16'h0000, 16'h0001, 16'h0000);
    directed("overflow",  '{16'h7F00, 16'h0000}, '{16'h0200, 16'h0000}, '{16'h0100, 16'h0000},
             16'h8100, 16'h0000, 16'h7D00, 16'h0000);

    repeat (160) begin
      rand_inputs();
      step();
    end

    // Abort a frame just before its add edge.
    while (k % 8 != 2) begin
      rand_inputs();
      step();
    end
    apply_reset();
    repeat (2) step();
    rst_n = 1'b1;

    directed("post_rst",  '{16'h0300, 16'h0100}, '{16'h0200, 16'hFC00}, '{16'hFF00, 16'h0500},
             16'h1500, 16'h0F00, 16'hF100, 16'hF300);

    repeat (40) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
